// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares the SDRAM controller command port among display, draw and aux requesters; define DDR_ARB_TIMEOUT_EN to enable the watchdog
module ddr_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 1023
) (
    input  logic        clk133_p,
    input  logic        rst_n,
    input  logic        dispRead,
    input  logic [23:0] dispAddress,
    output logic        dispAck,
    output logic [31:0] dispData,
    input  logic        drawWrite,
    input  logic [23:0] drawAddress,
    input  logic [15:0] drawData,
    output logic        drawAck,
    input  logic        auxRead,
    input  logic [23:0] auxAddress,
    output logic        auxAck,
    output logic [31:0] auxData,
    output logic        ddrRead,
    output logic [23:0] ddrReadAddress,
    input  logic        ddrReadAcknowledge,
    input  logic [31:0] ddrReadData,
    output logic        ddrWrite,
    output logic [23:0] ddrWriteAddress,
    input  logic        ddrWriteAcknowledge,
    output logic [15:0] ddrWriteData,
    output logic        timeoutError
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RELEASE} state_t;
    typedef enum logic [1:0] {P_DISP, P_DRAW, P_AUX} port_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state, state_nx;
    port_t owner, owner_nx;
    logic rr_aux, rr_aux_nx;
    logic [3:0] starve, starve_nx;
    logic rd_nx, wr_nx, dack_nx, drack_nx, aack_nx;
    logic [23:0] raddr_nx, waddr_nx;
    logic [15:0] wdata_nx;
    logic [31:0] ddata_nx, adata_nx;
    logic other, pick_disp, pick_draw, pick_aux, cur_ack, expire;
    assign other     = drawWrite | auxRead;
    assign pick_disp = dispRead & ((starve < LIMIT) | ~other);
    assign pick_draw = ~pick_disp & drawWrite & (~auxRead | ~rr_aux);
    assign pick_aux  = ~pick_disp & auxRead & (~drawWrite | rr_aux);
    assign cur_ack   = (owner == P_DRAW) ? ddrWriteAcknowledge : ddrReadAcknowledge;
`ifdef DDR_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] wd;
    assign expire = (state == READ || state == WRITE) && !cur_ack && wd == TO_LAST;
    // watchdog: counts cycles an operation is outstanding, sticky error on expiry
    always_ff @(posedge clk133_p or negedge rst_n) begin
        if (!rst_n) begin
            wd           <= '0;
            timeoutError <= 1'b0;
        end else begin
            wd <= (state == READ || state == WRITE) ? wd + 10'd1 : '0;
            if (expire) timeoutError <= 1'b1;
        end
    end
`else
    assign expire       = 1'b0;
    assign timeoutError = 1'b0;
`endif
    // next state, grant selection and registered output values
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_aux_nx = rr_aux;
        starve_nx = starve;
        rd_nx     = ddrRead;
        wr_nx     = ddrWrite;
        raddr_nx  = ddrReadAddress;
        waddr_nx  = ddrWriteAddress;
        wdata_nx  = ddrWriteData;
        ddata_nx  = dispData;
        adata_nx  = auxData;
        dack_nx   = 1'b0;
        drack_nx  = 1'b0;
        aack_nx   = 1'b0;
        case (state)
            IDLE: if (!ddrReadAcknowledge && !ddrWriteAcknowledge) begin
                starve_nx = other ? starve : '0;
                if (pick_disp) begin
                    state_nx  = READ;
                    owner_nx  = P_DISP;
                    rd_nx     = 1'b1;
                    raddr_nx  = dispAddress;
                    starve_nx = !other ? '0 : (starve == 4'hF) ? starve : starve + 4'd1;
                end else if (pick_draw) begin
                    state_nx  = WRITE;
                    owner_nx  = P_DRAW;
                    wr_nx     = 1'b1;
                    waddr_nx  = drawAddress;
                    wdata_nx  = drawData;
                    rr_aux_nx = 1'b1;
                    starve_nx = '0;
                end else if (pick_aux) begin
                    state_nx  = READ;
                    owner_nx  = P_AUX;
                    rd_nx     = 1'b1;
                    raddr_nx  = auxAddress;
                    rr_aux_nx = 1'b0;
                    starve_nx = '0;
                end
            end
            READ, WRITE: if (cur_ack || expire) begin
                state_nx = RELEASE;
                rd_nx    = 1'b0;
                wr_nx    = 1'b0;
                dack_nx  = cur_ack && owner == P_DISP;
                drack_nx = cur_ack && owner == P_DRAW;
                aack_nx  = cur_ack && owner == P_AUX;
                ddata_nx = dack_nx ? ddrReadData : dispData;
                adata_nx = aack_nx ? ddrReadData : auxData;
            end
            RELEASE: state_nx = cur_ack ? RELEASE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state and output registers
    always_ff @(posedge clk133_p or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            owner           <= P_DISP;
            rr_aux          <= 1'b0;
            starve          <= '0;
            ddrRead         <= 1'b0;
            ddrWrite        <= 1'b0;
            ddrReadAddress  <= '0;
            ddrWriteAddress <= '0;
            ddrWriteData    <= '0;
            dispData        <= '0;
            auxData         <= '0;
            dispAck         <= 1'b0;
            drawAck         <= 1'b0;
            auxAck          <= 1'b0;
        end else begin
            state           <= state_nx;
            owner           <= owner_nx;
            rr_aux          <= rr_aux_nx;
            starve          <= starve_nx;
            ddrRead         <= rd_nx;
            ddrWrite        <= wr_nx;
            ddrReadAddress  <= raddr_nx;
            ddrWriteAddress <= waddr_nx;
            ddrWriteData    <= wdata_nx;
            dispData        <= ddata_nx;
            auxData         <= adata_nx;
            dispAck         <= dack_nx;
            drawAck         <= drack_nx;
            auxAck          <= aack_nx;
        end
    end
endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: scoreboard bench for ddr_arbiter with a simple level-ack controller model
module tb_ddr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dispRead, drawWrite, auxRead;
    logic [23:0] dispAddress, drawAddress, auxAddress;
    logic [15:0] drawData;
    logic        dispAck, drawAck, auxAck;
    logic [31:0] dispData, auxData;
    logic        ddrRead, ddrWrite;
    logic [23:0] ddrReadAddress, ddrWriteAddress;
    logic        ddrReadAcknowledge, ddrWriteAcknowledge;
    logic [31:0] ddrReadData;
    logic [15:0] ddrWriteData;
    logic        timeoutError;

    typedef struct {
        int          port;
        logic [23:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0;
    int lat = 6;
    logic ctrl_en = 1'b0, ctrl_mute = 1'b0;
    logic [23:0] seen_addr = '0;
    logic [15:0] seen_wdata = '0;
    logic stable = 1'b1;

    always #5 clk = ~clk;

    ddr_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(20)) dut (
        .clk133_p(clk), .rst_n(rst_n),
        .dispRead(dispRead), .dispAddress(dispAddress), .dispAck(dispAck), .dispData(dispData),
        .drawWrite(drawWrite), .drawAddress(drawAddress), .drawData(drawData), .drawAck(drawAck),
        .auxRead(auxRead), .auxAddress(auxAddress), .auxAck(auxAck), .auxData(auxData),
        .ddrRead(ddrRead), .ddrReadAddress(ddrReadAddress), .ddrReadAcknowledge(ddrReadAcknowledge),
        .ddrReadData(ddrReadData), .ddrWrite(ddrWrite), .ddrWriteAddress(ddrWriteAddress),
        .ddrWriteAcknowledge(ddrWriteAcknowledge), .ddrWriteData(ddrWriteData),
        .timeoutError(timeoutError)
    );

    function automatic logic [31:0] rd_fn(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEADBEEF : {8'hD0, a};
    endfunction

    function automatic logic ackof(input int p);
        return (p == 0) ? dispAck : (p == 1) ? drawAck : auxAck;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [23:0] a, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.addr = a;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic set_req(input int p, input logic v, input logic [23:0] a, input logic [15:0] wd);
        if (p == 0) begin dispRead = v; dispAddress = a; end
        else if (p == 1) begin drawWrite = v; drawAddress = a; drawData = wd; end
        else begin auxRead = v; auxAddress = a; end
    endtask

    task automatic wait_ack(input int p);
        int n = 0;
        while (!ackof(p) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ack_arrived", 32'(n < 200), 1);
    endtask

    task automatic req(input int p, input logic [23:0] a, input logic [15:0] wd, input logic [31:0] ed);
        push(p, a, ed);
        @(negedge clk);
        set_req(p, 1'b1, a, wd);
        @(negedge clk);
        chk("issue_req", (p == 1) ? ddrWrite : ddrRead, 1);
        chk("issue_addr", (p == 1) ? ddrWriteAddress : ddrReadAddress, a);
        if (p == 1) chk("issue_wdata", ddrWriteData, wd);
        wait_ack(p);
        set_req(p, 1'b0, a, wd);
    endtask

    // controller model: acks a request lat cycles after seeing it, holds ack until the request drops
    initial begin
        ddrReadAcknowledge  = 1'b0;
        ddrWriteAcknowledge = 1'b0;
        ddrReadData         = '0;
        forever begin
            @(negedge clk);
            if (ctrl_en && rst_n && (ddrRead || ddrWrite)) begin
                automatic logic is_wr = ddrWrite;
                seen_addr  = is_wr ? ddrWriteAddress : ddrReadAddress;
                seen_wdata = ddrWriteData;
                stable     = 1'b1;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                    if (is_wr && (!ddrWrite || ddrWriteAddress !== seen_addr || ddrWriteData !== seen_wdata)) stable = 1'b0;
                end
                if (rst_n && !ctrl_mute) begin
                    if (is_wr) ddrWriteAcknowledge = 1'b1;
                    else begin
                        ddrReadAcknowledge = 1'b1;
                        ddrReadData        = rd_fn(seen_addr);
                    end
                end
                for (int i = 0; i < 64 && (ddrRead || ddrWrite); i++) @(negedge clk);
                ddrReadAcknowledge  = 1'b0;
                ddrWriteAcknowledge = 1'b0;
                ddrReadData         = '0;
            end
        end
    end

    // monitor: pops the scoreboard on every requester ack pulse
    initial begin
        forever begin
            @(negedge clk);
            if (ddrRead && ddrWrite) begin
                errors++;
                $display("FAIL both_req actual=11 required=not both");
            end
            if (dispAck || drawAck || auxAck) begin
                automatic int port = dispAck ? 0 : drawAck ? 1 : 2;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack actual=port%0d required=none", port);
                end else begin
                    automatic exp_t e = sbq.pop_front();
                    chk("ack_port", port, e.port);
                    chk("ack_onehot", 32'(dispAck) + 32'(drawAck) + 32'(auxAck), 1);
                    chk("ack_addr", seen_addr, e.addr);
                    chk("ack_req_low", {ddrRead, ddrWrite}, 0);
                    if (port == 0) chk("disp_data", dispData, e.data);
                    if (port == 2) chk("aux_data", auxData, e.data);
                    if (port == 1) begin
                        chk("wr_data", seen_wdata, e.data);
                        chk("wr_stable", stable, 1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, hi;
        rst_n = 1'b0;
        dispRead = 0; drawWrite = 0; auxRead = 0;
        dispAddress = '0; drawAddress = '0; auxAddress = '0; drawData = '0;
        // reset with a stale read ack from the controller
        #1 ddrReadAcknowledge = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {ddrRead, ddrWrite, dispAck, drawAck, auxAck, timeoutError}, 0);
        chk("rst_raddr", ddrReadAddress, 0);
        chk("rst_ddata", dispData, 0);
        chk("rst_adata", auxData, 0);
        rst_n = 1'b1;
        push(0, 24'h000040, rd_fn(24'h000040));
        dispRead = 1'b1;
        dispAddress = 24'h000040;
        repeat (5) @(negedge clk);
        chk("stale_hold", {ddrRead, ddrWrite}, 0);
        ddrReadAcknowledge = 1'b0;
        ctrl_en = 1'b1;
        @(negedge clk);
        chk("stale_issue", ddrRead, 1);
        chk("stale_addr", ddrReadAddress, 24'h000040);
        wait_ack(0);
        dispRead = 1'b0;
        // starvation bound: all three held, display limited to 8 in a row
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) push(0, 24'h000200, rd_fn(24'h000200));
            if (k == 1) push(2, 24'h000400, rd_fn(24'h000400));
            else push(1, 24'h000300, 32'h0000_1234);
        end
        @(negedge clk);
        set_req(0, 1'b1, 24'h000200, 16'h0);
        set_req(1, 1'b1, 24'h000300, 16'h1234);
        set_req(2, 1'b1, 24'h000400, 16'h0);
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("starve_done", 32'(n < 2000), 1);
        dispRead = 0; drawWrite = 0; auxRead = 0;
        // single display read and single draw write
        req(0, 24'h000100, 16'h0, 32'hDEADBEEF);
        req(1, 24'h123456, 16'hA5A5, 32'h0000_A5A5);
        req(2, 24'h00ABCD, 16'h0, rd_fn(24'h00ABCD));
        // reset in the middle of a write
        @(negedge clk);
        set_req(1, 1'b1, 24'h0ABCDE, 16'h5555);
        n = 0;
        while (!ddrWrite && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_write_issue", ddrWrite, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {ddrRead, ddrWrite, dispAck, drawAck, auxAck, timeoutError}, 0);
        chk("rst_mid_waddr", ddrWriteAddress, 0);
        chk("rst_mid_wdata", ddrWriteData, 0);
        chk("rst_mid_ddata", dispData, 0);
        drawWrite = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_idle", {ddrRead, ddrWrite}, 0);
`ifdef DDR_ARB_TIMEOUT_EN
        // watchdog: controller never acks
        ctrl_mute = 1'b1;
        set_req(0, 1'b1, 24'h000500, 16'h0);
        n = 0;
        while (!ddrRead && n < 20) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        while (ddrRead && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        chk("wd_len", hi, 20);
        chk("wd_flag", timeoutError, 1);
        dispRead = 1'b0;
        repeat (3) @(negedge clk);
        ctrl_mute = 1'b0;
        req(0, 24'h000600, 16'h0, rd_fn(24'h000600));
        chk("wd_sticky", timeoutError, 1);
`else
        hi = 0;
        chk("wd_off", timeoutError, 0);
`endif
        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_arbiter.md
# ddr_arbiter

Shares the single DDR read/write command port of the SDRAM controller among three requesters: the display pixel fetch (read), the drawing engine (write) and an auxiliary readback port (read). It issues one DDR operation at a time, follows the controller's level acknowledge handshake, and returns a one-cycle acknowledge pulse with read data to the winning requester. Display reads have priority, bounded by an anti-starvation counter.

## Interface
- STARVE_LIMIT, 8: consecutive display grants allowed while another requester waits (1..15).
- TIMEOUT, 1023: watchdog limit in cycles, used only with the macro below (10-bit counter).
- clk133_p  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dispRead  in  1  display read request; held with address until dispAck.
- dispAddress  in  24  display word address.
- dispAck  out  1  one-cycle pulse; dispData valid in the same cycle.
- dispData  out  32  display read data.
- drawWrite  in  1  draw write request; held with address and data until drawAck.
- drawAddress  in  24  draw word address.
- drawData  in  16  draw write data.
- drawAck  out  1  one-cycle completion pulse.
- auxRead  in  1  auxiliary read request.
- auxAddress  in  24  auxiliary word address.
- auxAck  out  1  one-cycle pulse; auxData valid in the same cycle.
- auxData  out  32  auxiliary read data.
- ddrRead  out  1  read request to controller.
- ddrReadAddress  out  24  read address to controller.
- ddrReadAcknowledge  in  1  controller read ack (level, held until ddrRead drops).
- ddrReadData  in  32  controller read data, valid while ddrReadAcknowledge high.
- ddrWrite  out  1  write request to controller.
- ddrWriteAddress  out  24  write address to controller.
- ddrWriteAcknowledge  in  1  controller write ack (level).
- ddrWriteData  out  16  write data, stable for the whole write.
- timeoutError  out  1  sticky watchdog flag.

## Operation
- Reset: state IDLE; all outputs 0; starve counter 0; round-robin pointer = draw.
- States: IDLE, READ (ddrRead high), WRITE (ddrWrite high), RELEASE (request low, waiting for ack low).
- IDLE issues only when ddrReadAcknowledge and ddrWriteAcknowledge are both 0 (covers reset mid-operation with a stale controller ack).
- Selection in IDLE: display if dispRead and (starve count < STARVE_LIMIT or no other request pending); otherwise the round-robin choice between draw and aux (pointer favours draw; after a grant, pointer moves to the other port).
- Starve counter: +1 on display grant while draw or aux pending (saturating); cleared on any draw/aux grant or when nothing else pending.
- On grant: latch address (and data for writes) into ddr outputs and port ID; READ or WRITE.
- READ/WRITE: hold request until the matching ack is seen high; then drop request, register ddrReadData into the owner's data output, pulse owner's ack, enter RELEASE.
- RELEASE: when the matching ack is low, go to IDLE.
- Data outputs hold the last value until the next ack to that port.
- Requests sampled only in IDLE; a request still high the cycle after its ack is a new request.

## Timing
- Request high before edge k in IDLE (acks low): ddr request and address valid after edge k.
- Controller ack high sampled at edge m: requester ack pulse and data valid after edge m, ddr request low after edge m.
- Minimum turnaround: RELEASE ≥1 cycle; next issue no earlier than edge m+2.
- Exactly one DDR operation outstanding; ddrRead and ddrWrite never high together.

## Configuration
- DDR_ARB_TIMEOUT_EN defined: counter runs in READ/WRITE; reaching TIMEOUT drops the request, sets timeoutError (cleared only by reset), pulses no ack, goes to RELEASE.
- Undefined: waits indefinitely; timeoutError tied 0.

## Test plan
- Single display read at 0x000100, controller acks after 6 cycles with 0xDEADBEEF -> dispAck one pulse, dispData=0xDEADBEEF, ddrRead low the same cycle.
- Draw write 0x123456 data 0xA5A5 -> ddrWriteAddress=0x123456, ddrWriteData=0xA5A5 stable until ack; drawAck single pulse.
- dispRead held continuously with drawWrite and auxRead pending, STARVE_LIMIT=8 -> 8 display grants, then draw, display×8, aux; alternation continues.
- ddrReadAcknowledge held high at reset release -> no request until it drops; then normal issue.
- rst_n low during WRITE -> all outputs 0 immediately; no ack pulse emitted.
- With DDR_ARB_TIMEOUT_EN, TIMEOUT=20, controller never acks -> request dropped after 20 cycles, timeoutError=1, no dispAck; next request served normally.
